rr_arbiter: RTL and testbench

Round-robin arbiter that shares one registered datapath resource (the clocked AND/register stage) between N requesters. It accepts level requests and issues a registered one-hot grant plus the grant index, which drives the datapath input mux. It sits between the requesting units and the shared stage and is the only block that sequences access to it.

---
 rtl/rr_arbiter_pkg.sv | 37 +++
 rtl/rr_arbiter_pick.sv | 22 ++
 rtl/rr_arbiter.sv | 128 ++++++++++++
 tb/tb_rr_arbiter.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/rr_arbiter_pkg.sv
// Shared types and the rotating-priority search used by the round-robin arbiter.
package rr_arbiter_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam int N_MAX     = 8;
   localparam int N_DEFAULT = 3;
   localparam int IDX_W     = $clog2(N_DEFAULT);

   typedef struct packed {
      logic       found;
      logic [2:0] idx;
   } pick_t;

   // Scanning from the top down lets the lowest rotated offset win without a break.
   function automatic pick_t next_pending(input logic [N_MAX-1:0] req,
                                          input logic [2:0]       start,
                                          input int               n);
      pick_t res;
      int    k;
      res = '0;
      for (int i = N_MAX - 1; i >= 0; i--) begin
         if (i < n) begin
            k = (int'(start) + i) % n;
            if (req[k]) begin
               res.found = 1'b1;
               res.idx   = 3'(k);
            end
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/rr_arbiter_pick.sv
// Combinational rotating-priority picker: first set request at or after ptr, wrapping modulo N.
module rr_pick
   import rr_arbiter_pkg::*;
#(
   parameter int N  = 3,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [IW-1:0] idx,
   output logic          found
);

   pick_t res;

   always_comb begin
      res   = next_pending(N_MAX'(req), 3'(ptr), N);
      idx   = IW'(res.idx);
      found = res.found;
   end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter for one shared registered stage; grants are registered and one-hot.
// Optional grant-length preemption is compiled in with RR_ARBITER_PREEMPT_EN.
module rr_arbiter
   import rr_arbiter_pkg::*;
#(
   parameter int N        = 3,
   parameter int HOLD_MAX = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N-1:0]         req,
   output logic [N-1:0]         gnt,
   output logic [$clog2(N)-1:0] gnt_id,
   output logic                 busy
);

   localparam int          IW  = $clog2(N);
   localparam logic [N-1:0] ONE = N'(1);

   if (N < 2 || N > N_MAX || HOLD_MAX < 2) begin : g_param_check
      $error("rr_arbiter: N must be 2..8 and HOLD_MAX at least 2");
   end

   state_t        state_q, state_d;
   logic [N-1:0]  gnt_q, gnt_d;
   logic [IW-1:0] gnt_id_q, gnt_id_d;
   logic [IW-1:0] ptr_q, ptr_d;
   logic          busy_q, busy_d;

   logic [N-1:0]  pick_req;
   logic [IW-1:0] pick_idx;
   logic          pick_found;
   logic          owner_req;
   logic          take;

`ifdef RR_ARBITER_PREEMPT_EN
   localparam int CNT_W = $clog2(HOLD_MAX);
   logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

   // While granted the owner is masked out, so found means "someone else is waiting".
   // ptr always equals owner+1 in GRANT, so one picker serves both arbitration points.
   assign pick_req  = (state_q == GRANT) ? (req & ~gnt_q) : req;
   assign owner_req = |(req & gnt_q);

   rr_pick #(
      .N  (N),
      .IW (IW)
   ) u_pick (
      .req   (pick_req),
      .ptr   (ptr_q),
      .idx   (pick_idx),
      .found (pick_found)
   );

   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      gnt_id_d = gnt_id_q;
      ptr_d    = ptr_q;
      busy_d   = busy_q;
      take     = 1'b0;
`ifdef RR_ARBITER_PREEMPT_EN
      cnt_d    = cnt_q;
`endif
      case (state_q)
         IDLE: begin
            take = pick_found;
         end
         GRANT: begin
            if (!owner_req) begin
               if (pick_found) begin
                  take = 1'b1;
               end else begin
                  state_d = IDLE;
                  gnt_d   = '0;
                  busy_d  = 1'b0;
               end
`ifdef RR_ARBITER_PREEMPT_EN
            end else if (cnt_q == CNT_W'(HOLD_MAX - 1)) begin
               take = pick_found;
            end else begin
               cnt_d = cnt_q + 1'b1;
`endif
            end
         end
         default: state_d = IDLE;
      endcase

      if (take) begin
         state_d  = GRANT;
         gnt_d    = ONE << pick_idx;
         gnt_id_d = pick_idx;
         busy_d   = 1'b1;
         ptr_d    = IW'((int'(pick_idx) + 1) % N);
`ifdef RR_ARBITER_PREEMPT_EN
         cnt_d    = '0;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         gnt_q    <= '0;
         gnt_id_q <= '0;
         ptr_q    <= '0;
         busy_q   <= 1'b0;
`ifdef RR_ARBITER_PREEMPT_EN
         cnt_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         gnt_id_q <= gnt_id_d;
         ptr_q    <= ptr_d;
         busy_q   <= busy_d;
`ifdef RR_ARBITER_PREEMPT_EN
         cnt_q    <= cnt_d;
`endif
      end
   end

   assign gnt    = gnt_q;
   assign gnt_id = gnt_id_q;
   assign busy   = busy_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed scoreboard bench for rr_arbiter (N=3, HOLD_MAX=4); honours RR_ARBITER_PREEMPT_EN.
module tb_rr_arbiter;

   localparam int N        = 3;
   localparam int HOLD_MAX = 4;

   logic         clk;
   logic         rst_n;
   logic [N-1:0] req;
   logic [N-1:0] gnt;
   logic [1:0]   gnt_id;
   logic         busy;

   typedef struct {
      logic [2:0] gnt;
      logic       busy;
      logic [1:0] id;
      logic       chk_id;
      string      tag;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   rr_arbiter #(
      .N        (N),
      .HOLD_MAX (HOLD_MAX)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    (req),
      .gnt    (gnt),
      .gnt_id (gnt_id),
      .busy   (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "bench timed out");
   end

   task automatic push_exp(input logic [2:0] g, input logic b, input logic [1:0] id,
                           input logic chk_id, input string tag);
      exp_t e;
      e.gnt = g; e.busy = b; e.id = id; e.chk_id = chk_id; e.tag = tag;
      sb.push_back(e);
   endtask

   task automatic check_pop();
      exp_t e;
      tests++;
      assert (sb.size() != 0) else begin
         fails++;
         $error("FAIL scoreboard observed=empty expected=entry");
      end
      if (sb.size() != 0) begin
         e = sb.pop_front();
         tests++;
         assert (gnt === e.gnt) else begin
            fails++;
            $error("FAIL %s gnt observed=%b expected=%b", e.tag, gnt, e.gnt);
         end
         tests++;
         assert (busy === e.busy) else begin
            fails++;
            $error("FAIL %s busy observed=%b expected=%b", e.tag, busy, e.busy);
         end
         if (e.chk_id) begin
            tests++;
            assert (gnt_id === e.id) else begin
               fails++;
               $error("FAIL %s gnt_id observed=%0d expected=%0d", e.tag, gnt_id, e.id);
            end
         end
      end
   endtask

   // Drive req at the falling edge, check the registered result just after the rising edge.
   task automatic step(input logic [2:0] r, input logic [2:0] g, input logic b,
                       input logic [1:0] id, input string tag);
      @(negedge clk);
      req = r;
      push_exp(g, b, id, b, tag);
      @(posedge clk);
      #1;
      check_pop();
   endtask

   task automatic reset_pulse(input string tag);
      @(negedge clk);
      rst_n = 1'b0;
      req   = '0;
      push_exp(3'b000, 1'b0, 2'd0, 1'b1, tag);
      #1;
      check_pop();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic release_and_check(input logic [2:0] r, input logic [2:0] g,
                                    input logic [1:0] id, input string tag);
      @(negedge clk);
      rst_n = 1'b1;
      req   = r;
      push_exp(g, 1'b1, id, 1'b1, tag);
      @(posedge clk);
      #1;
      check_pop();
   endtask

   initial begin
      logic [2:0] exp_g;
      rst_n = 1'b0;
      req   = 3'b111;

      // Reset held with all requests asserted, then first grant goes to 0.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         push_exp(3'b000, 1'b0, 2'd0, 1'b1, "reset_hold");
         @(posedge clk);
         #1;
         check_pop();
      end
      release_and_check(3'b111, 3'b001, 2'd0, "reset_release");
      step(3'b000, 3'b000, 1'b0, 2'd0, "release_to_idle");

      // Single requester: 1-cycle grant latency, 1-cycle release latency.
      step(3'b010, 3'b010, 1'b1, 2'd1, "single_grant");
      for (int i = 0; i < 4; i++) step(3'b010, 3'b010, 1'b1, 2'd1, "single_hold");
      step(3'b000, 3'b000, 1'b0, 2'd0, "single_release");

      // All requesting, owners drop for one cycle: order 0,1,2,0 with no idle gap.
      reset_pulse("reset_before_rotate");
      step(3'b111, 3'b001, 1'b1, 2'd0, "rot_g0");
      step(3'b111, 3'b001, 1'b1, 2'd0, "rot_g0_hold");
      step(3'b110, 3'b010, 1'b1, 2'd1, "rot_g1");
      step(3'b111, 3'b010, 1'b1, 2'd1, "rot_g1_hold");
      step(3'b101, 3'b100, 1'b1, 2'd2, "rot_g2");
      step(3'b111, 3'b100, 1'b1, 2'd2, "rot_g2_hold");
      step(3'b011, 3'b001, 1'b1, 2'd0, "rot_wrap_g0");

      // Back-to-back handoff and glitch immunity of non-owner requests.
      step(3'b011, 3'b001, 1'b1, 2'd0, "handoff_hold0");
      step(3'b010, 3'b010, 1'b1, 2'd1, "handoff_to1");
      step(3'b011, 3'b010, 1'b1, 2'd1, "glitch_ignored");
      step(3'b010, 3'b010, 1'b1, 2'd1, "glitch_gone");
      step(3'b000, 3'b000, 1'b0, 2'd0, "handoff_idle");

      // Constant req=101: preemption alternates every HOLD_MAX cycles, otherwise 0 keeps it.
      reset_pulse("reset_before_preempt");
      for (int i = 0; i < 12; i++) begin
`ifdef RR_ARBITER_PREEMPT_EN
         exp_g = (((i / HOLD_MAX) % 2) == 0) ? 3'b001 : 3'b100;
`else
         exp_g = 3'b001;
`endif
         step(3'b101, exp_g, 1'b1, (exp_g == 3'b100) ? 2'd2 : 2'd0, "preempt_pattern");
      end

      // Asynchronous reset mid-cycle while requester 2 owns the grant.
      reset_pulse("reset_before_async");
      step(3'b100, 3'b100, 1'b1, 2'd2, "async_setup_g2");
      #2;
      rst_n = 1'b0;
      push_exp(3'b000, 1'b0, 2'd0, 1'b1, "async_reset_clear");
      #1;
      check_pop();
      release_and_check(3'b111, 3'b001, 2'd0, "ptr_reset_to0");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
